// File: rtl/xalu_ise_issue.sv
// rtl/xalu_ise_issue.sv - issue sequencer between the pipeline and a custom-instruction ALU
//
// Purpose: accepts one custom instruction at a time from the pipeline and
// presents its operands to the ISE ALU. It waits up to TIMEOUT cycles for a
// result and returns either that result or an illegal-instruction response.
// TIMEOUT legal range is 1..15.
//
// Ports:
//   ise_clk, ise_rst        clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE without flush)
//   req_fn/imm/rs1/rs2/rd   request payload
//   flush                   pipeline kill, drops any in-flight request
//   ise_fn/imm/in1/in2/val  operands presented to the ISE ALU
//   ise_oval/ise_out        ISE ALU result (may be combinational from ise_val)
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/rd/illegal     response payload

module xalu_ise_issue #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_fn,
  input  logic [6:0]  req_imm,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [5:0]  ise_fn,
  output logic [6:0]  ise_imm,
  output logic [31:0] ise_in1,
  output logic [31:0] ise_in2,
  output logic        ise_val,
  input  logic        ise_oval,
  input  logic [31:0] ise_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Counter value on the last cycle the ALU is given before the request is
  // declared illegal.
  localparam logic [3:0] LP_CNT_LAST = 4'(TIMEOUT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [5:0]  r_fn;
  logic [6:0]  r_imm;
  logic [31:0] r_in1;
  logic [31:0] r_in2;
  logic [4:0]  r_rd;
  logic        r_ise_val;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic [4:0]  r_rsp_rd;
  logic        r_rsp_illegal;

  logic        w_accept;

  // Ready is combinational on flush so a kill in IDLE blocks acceptance in the same cycle.
  assign req_ready = (r_state == S_IDLE) && !flush;
  assign w_accept  = req_ready && req_valid;

  assign ise_fn      = r_fn;
  assign ise_imm     = r_imm;
  assign ise_in1     = r_in1;
  assign ise_in2     = r_in2;
  assign ise_val     = r_ise_val;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_rd      = r_rsp_rd;
  assign rsp_illegal = r_rsp_illegal;

  always_ff @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_fn          <= 6'd0;
      r_imm         <= 7'd0;
      r_in1         <= 32'd0;
      r_in2         <= 32'd0;
      r_rd          <= 5'd0;
      r_ise_val     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= 32'd0;
      r_rsp_rd      <= 5'd0;
      r_rsp_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fn      <= req_fn;
            r_imm     <= req_imm;
            r_in1     <= req_rs1;
            r_in2     <= req_rs2;
            r_rd      <= req_rd;
            r_cnt     <= 4'd0;
            r_ise_val <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Priority: flush, then a result, then timeout.
          if (flush) begin
            r_ise_val <= 1'b0;
            r_state   <= S_IDLE;
          end else if (ise_oval) begin
            r_rsp_data    <= ise_out;
            r_rsp_illegal <= 1'b0;
            r_rsp_rd      <= r_rd;
            r_rsp_valid   <= 1'b1;
            r_ise_val     <= 1'b0;
            r_state       <= S_RESP;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_rsp_data    <= 32'd0;
            r_rsp_illegal <= 1'b1;
            r_rsp_rd      <= r_rd;
            r_rsp_valid   <= 1'b1;
            r_ise_val     <= 1'b0;
            r_state       <= S_RESP;
          end else if (r_cnt != 4'hF) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          // Payload is left untouched on exit; only the valid drops.
          if (flush || rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_ise_val   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_ise_issue.sv
// tb/tb_xalu_ise_issue.sv - scoreboard testbench for xalu_ise_issue

module tb_xalu_ise_issue;

  logic        ise_clk;
  logic        ise_rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_fn;
  logic [6:0]  req_imm;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic [5:0]  ise_fn;
  logic [6:0]  ise_imm;
  logic [31:0] ise_in1;
  logic [31:0] ise_in2;
  logic        ise_val;
  logic        ise_oval;
  logic [31:0] ise_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_illegal;
  logic        alu_force;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Expected responses: {rd, illegal, data}
  logic [37:0] sb[$];

  xalu_ise_issue #(.TIMEOUT(4)) dut (
    .ise_clk(ise_clk), .ise_rst(ise_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fn(req_fn), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .flush(flush),
    .ise_fn(ise_fn), .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2), .ise_val(ise_val),
    .ise_oval(ise_oval), .ise_out(ise_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal)
  );

  // ALU model: fn 0 is unsupported and never answers; others return in1 ^ in2 at once.
  assign ise_oval = (ise_val && (ise_fn != 6'd0)) || alu_force;
  assign ise_out  = alu_force ? 32'hCAFEF00D : (ise_in1 ^ ise_in2);

  initial ise_clk = 1'b0;
  always #5 ise_clk = ~ise_clk;
  always @(posedge ise_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every consumed response is compared against the head of the scoreboard.
  always @(negedge ise_clk) begin
    if (ise_rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {rsp_rd, rsp_illegal, rsp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("rsp_payload", {rsp_rd, rsp_illegal, rsp_data}, sb.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [5:0] fn, input logic [6:0] imm, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
    req_fn = fn; req_imm = imm; req_rs1 = a; req_rs2 = b; req_rd = rd;
    req_valid = 1'b1;
    @(negedge ise_clk);
    check("accept_ready", req_ready, 1);
    @(posedge ise_clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    bit got;
    int t0, t1;
    ise_rst = 1'b0; req_valid = 1'b0; req_fn = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; flush = 1'b0; rsp_ready = 1'b1; alu_force = 1'b0;

    // Reset state
    repeat (2) @(posedge ise_clk);
    @(negedge ise_clk);
    check("rst_ctrl", {ise_val, rsp_valid, rsp_illegal}, 3'b000);
    check("rst_rsp", {rsp_rd, rsp_data}, 0);
    check("rst_ise", {ise_fn, ise_imm, ise_in1, ise_in2}, 0);
    @(posedge ise_clk); #1 ise_rst = 1'b1;
    @(negedge ise_clk);
    check("ready_after_rst", req_ready, 1);

    // ALU output outside ISSUE is ignored
    @(posedge ise_clk); #1 alu_force = 1'b1;
    repeat (2) @(negedge ise_clk);
    check("idle_oval_ignored", {rsp_valid, ise_val, req_ready}, 3'b001);
    @(posedge ise_clk); #1 alu_force = 1'b0;

    // Single-cycle ALU: rsp_valid two cycles after accept
    sb.push_back({5'd5, 1'b0, 32'h88888888});
    send(6'b000001, 7'h00, 32'h01234567, 32'h89ABCDEF, 5'd5);
    @(negedge ise_clk);
    check("n1_ise_val", {ise_val, rsp_valid, req_ready}, 3'b100);
    check("n1_ops", {ise_fn, ise_in1, ise_in2}, {6'b000001, 32'h01234567, 32'h89ABCDEF});
    @(negedge ise_clk);
    check("n2_rsp_valid", {rsp_valid, ise_val}, 2'b10);
    @(negedge ise_clk);
    check("n3_idle", {rsp_valid, req_ready}, 2'b01);

    // Unsupported fn: timeout after 4 issue cycles
    @(posedge ise_clk); #1;
    sb.push_back({5'd7, 1'b1, 32'h0});
    send(6'b000000, 7'h11, 32'h0000DEAD, 32'h1, 5'd7);
    cnt = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ise_clk);
      if (i == 0) check("to_imm", ise_imm, 7'h11);
      if (rsp_valid) begin got = 1; break; end
      if (ise_val) cnt++;
    end
    check("to_rsp_seen", got, 1);
    check("to_ise_val_cycles", cnt, 4);
    check("to_payload", {rsp_illegal, rsp_data}, {1'b1, 32'h0});
    @(posedge ise_clk); #1;

    // Backpressure: payload held for 5 stalled cycles
    rsp_ready = 1'b0;
    sb.push_back({5'd9, 1'b0, 32'hFFFFFFFF});
    send(6'b000010, 7'h05, 32'hFFFF0000, 32'h0000FFFF, 5'd9);
    @(negedge ise_clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge ise_clk);
      check("stall_hold", {rsp_valid, req_ready, rsp_rd, rsp_illegal, rsp_data},
            {1'b1, 1'b0, 5'd9, 1'b0, 32'hFFFFFFFF});
    end
    @(posedge ise_clk); #1 rsp_ready = 1'b1;
    @(negedge ise_clk);
    check("stall_release_valid", rsp_valid, 1);
    @(negedge ise_clk);
    check("stall_consumed", {rsp_valid, req_ready}, 2'b01);

    // Flush in the same cycle as ise_oval
    @(posedge ise_clk); #1;
    send(6'b000011, 7'h00, 32'h5, 32'h6, 5'd3);
    flush = 1'b1;
    @(negedge ise_clk);
    check("flush_oval_cycle", {ise_val, ise_oval, req_ready}, 3'b110);
    @(posedge ise_clk); #1 flush = 1'b0;
    @(negedge ise_clk);
    check("flush_idle", {rsp_valid, ise_val, req_ready}, 3'b001);
    got = 0;
    repeat (3) begin @(negedge ise_clk); if (rsp_valid) got = 1; end
    check("flush_no_rsp", got, 0);

    // Asynchronous reset mid-ISSUE
    @(posedge ise_clk); #1;
    send(6'b000000, 7'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
    @(negedge ise_clk);
    check("pre_rst_issue", {ise_val, ise_in1}, {1'b1, 32'hFFFFFFFF});
    #2 ise_rst = 1'b0;
    #1;
    check("async_rst", {ise_val, ise_in1, ise_in2}, 0);
    @(posedge ise_clk); #1 ise_rst = 1'b1;
    @(negedge ise_clk);
    check("rst_release_ready", req_ready, 1);
    got = 0;
    repeat (6) begin @(negedge ise_clk); if (rsp_valid) got = 1; end
    check("rst_no_rsp", got, 0);

    // Back-to-back requests with req_valid held
    @(posedge ise_clk); #1;
    sb.push_back({5'd10, 1'b0, 32'h000000FF});
    sb.push_back({5'd11, 1'b0, 32'h12345678});
    req_fn = 6'd1; req_imm = 7'd0; req_rs1 = 32'h000000F0; req_rs2 = 32'h0000000F; req_rd = 5'd10;
    req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin @(negedge ise_clk); if (req_ready) begin got = 1; break; end end
    check("b2b_first_accept", got, 1);
    t0 = cyc;
    @(posedge ise_clk); #1;
    req_rs1 = 32'h12340000; req_rs2 = 32'h00005678; req_rd = 5'd11;
    got = 0;
    for (int i = 0; i < 10; i++) begin @(negedge ise_clk); if (req_ready) begin got = 1; break; end end
    check("b2b_second_accept", got, 1);
    t1 = cyc;
    @(posedge ise_clk); #1 req_valid = 1'b0;
    check("b2b_interval", t1 - t0, 3);
    repeat (6) @(negedge ise_clk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xalu_ise_issue.md
XALU_ISE_ISSUE -- requirements
Module: xalu_ise_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4, max cycles ise_val is held without ise_oval before the request completes as illegal (legal range 1..15).
REQ-002 SHALL have port ise_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port ise_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline offers a custom instruction.
REQ-005 SHALL have port req_ready  output  1  issuer accepts the request this cycle.
REQ-006 SHALL have port req_fn  input  6  function/opcode select (bits[1:0] = CUSTOM_0..3).
REQ-007 SHALL have port req_imm  input  7  funct field.
REQ-008 SHALL have port req_rs1, req_rs2  input  32 each  source operands.
REQ-009 SHALL have port req_rd  input  5  destination register tag.
REQ-010 SHALL have port flush  input  1  pipeline kill; drops any in-flight request.
REQ-011 SHALL have ports ise_fn (output, 6), ise_imm (output, 7), ise_in1 (output, 32), ise_in2 (output, 32), ise_val (output, 1), which drive the ISE ALU.
REQ-012 SHALL have ports ise_oval (input, 1), ise_out (input, 32), the ISE ALU result; may be combinational from ise_val.
REQ-013 SHALL have port rsp_valid  output  1  result available.
REQ-014 SHALL have port rsp_ready  input  1  pipeline consumes the result.
REQ-015 SHALL have ports rsp_data (output, 32), rsp_rd (output, 5), rsp_illegal (output, 1) carrying the result, tag, and illegal-instruction flag.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE with flush=0.
REQ-018 In IDLE, on req_valid&req_ready, SHALL register fn/imm/rs1/rs2/rd, clear the timeout counter, and enter ISSUE.
REQ-019 In ISSUE, SHALL drive ise_val=1 and ise_fn/ise_imm/ise_in1/ise_in2 from the registers, stable every cycle until ISSUE exits.
REQ-020 Outside ISSUE, SHALL drive ise_val=0 and hold ise_fn/ise_imm/ise_in1/ise_in2 at their last registered values.
REQ-021 In ISSUE with ise_oval=1, SHALL capture ise_out into rsp_data, set rsp_illegal=0, and enter RESP.
REQ-022 In ISSUE with ise_oval=0, SHALL increment the counter.
REQ-023 When the counter equals TIMEOUT-1 and ise_oval=0, SHALL set rsp_data=0, set rsp_illegal=1, and enter RESP.
REQ-024 The counter SHALL be 4 bits and SHALL NOT wrap; ise_oval on the final allowed cycle SHALL take priority over timeout.
REQ-025 Latency SHALL be: accept at edge N; ise_val high in cycle N+1; ise_oval in cycle N+1 gives rsp_valid in cycle N+2.
REQ-026 In RESP, SHALL drive rsp_valid=1 and hold rsp_data/rsp_rd/rsp_illegal stable until rsp_ready=1, then return to IDLE.
REQ-027 rsp_valid SHALL be 0 in IDLE and ISSUE.
REQ-028 Minimum issue interval SHALL be 3 cycles, with no new acceptance in the RESP-exit cycle.
REQ-029 flush=1 in ISSUE or RESP SHALL return the FSM to IDLE next edge with no response produced.
REQ-030 flush SHALL win over simultaneous ise_oval, timeout, or rsp_ready.
REQ-031 flush=1 in IDLE SHALL block acceptance.
REQ-032 ise_oval/ise_out outside ISSUE SHALL be ignored.

Reset
REQ-033 On ise_rst=0 (asynchronous), SHALL force state IDLE, counter 0, and all of the following to 0: ise_val, rsp_valid, rsp_illegal, rsp_data, rsp_rd, ise_fn, ise_imm, ise_in1, ise_in2.
REQ-034 Reset mid-ISSUE or mid-RESP SHALL discard the request, with no rsp_valid after release.
REQ-035 req_ready SHALL be 1 in the first cycle after ise_rst deasserts (absent flush).

Verification
REQ-036 SHALL cover: req fn=6'b000001, imm=7'h00, rs1=32'h01234567, rs2=32'h89ABCDEF, rd=5 with ALU ise_oval same cycle -> ise_val 1 cycle; rsp_valid cycle N+2, rsp_data=ALU value, rsp_rd=5, rsp_illegal=0.
REQ-037 SHALL cover: unsupported fn=6'b000000 (ise_oval never 1), TIMEOUT=4 -> ise_val high exactly 4 cycles, then rsp_valid=1, rsp_illegal=1, rsp_data=0.
REQ-038 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and payload stable for 5 cycles, req_ready=0 throughout; the result is consumed on the first rsp_ready=1.
REQ-039 SHALL cover: flush asserted in the same cycle as ise_oval=1 -> no rsp_valid, IDLE next cycle, req_ready=1 the cycle after.
REQ-040 SHALL cover: ise_rst pulsed low during ISSUE with operands 32'hFFFFFFFF -> ise_val=0 and ise_in1=0 immediately (asynchronous), no response after release.
REQ-041 SHALL cover: back-to-back req_valid held high with two requests -> second accepted exactly 3 cycles after the first when rsp_ready=1, with correct tags in order.
